conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming 3x3 window generator that produces the nine taps consumed by the convolver's multiplier bank and adder tree. It accepts one raster-order pixel per handshake, keeps two line buffers, and emits every valid (unpadded) 3x3 neighbourhood as nine parallel signed words. Its tap order matches the adder-tree inputs 0..8, so win_k multiplies with kernel weight k.

## Interface
- DATA_WIDTH, 16, pixel and tap width (signed)
- IMG_WIDTH, 28, pixels per row; must be ≥ 3
- IMG_HEIGHT, 28, rows per frame; must be ≥ 3
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  pixel present
- in_ready  output  1  block can accept a pixel
- in_data  input  DATA_WIDTH  signed pixel, raster order (row-major, col 0 first)
- out_valid  output  1  window present on win_0..win_8
- out_ready  input  1  downstream accepts window
- win_0..win_8  output  DATA_WIDTH each  row-major taps: win_0 = top-left (row r-2, col c-2), win_8 = bottom-right (row r, col c)
- frame_last  output  1  qualifies the final window of a frame (valid only with out_valid)

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
- On accept: shift pixel into 3x3 register window and line buffers; advance col; at col = IMG_WIDTH-1 wrap col to 0, increment row; at last pixel of frame wrap row and col to 0. The next pixel starts a new frame with no gap.
- A window is emitted when the accepted pixel has row ≥ 2 and col ≥ 2. Windows never straddle rows, and the line buffers are not flushed between rows.
- Windows per frame: (IMG_HEIGHT-2)·(IMG_WIDTH-2); 676 at defaults.
- Output register holds window, out_valid and frame_last until out_valid && out_ready. It then loads the next window in the same cycle if a qualifying pixel is accepted, otherwise clears out_valid.
- frame_last = 1 for the window whose bottom-right is (IMG_HEIGHT-1, IMG_WIDTH-1).
- No arithmetic on data: taps are copies of stored pixels, with no width change.
- Reset: out_valid=0, frame_last=0, win_0..win_8=0, row=col=0, so in_ready=1. Line buffer and window contents are not cleared; stale data is never emitted because rows 0–1 are refilled before any window.
- Reset mid-frame: the frame is abandoned and the next accepted pixel is (0,0). Any held window is dropped.

## Timing
- Latency: a window appears (out_valid high) the cycle after its bottom-right pixel is accepted.
- Throughput: one pixel per cycle while out_ready is held high. Full-rate flow-through with no bubbles.
- Backpressure: while out_valid && !out_ready, in_ready=0 and the outputs are stable. Pixels that produce no window (row<2 or col<2) are also stalled by an unconsumed window, to keep order.
- Simultaneous consume and produce in one cycle: the new window replaces the old one, and out_valid stays 1.

## Configuration
- CONV_WINDOW_STRIDE2_EN defined: emit only windows whose bottom-right has even row and even col (stride 2). Count is ((H-3)/2+1)·((W-3)/2+1), giving 169 at defaults. frame_last marks the last emitted window.
- Undefined: stride 1 as above.

## Structure
- Shared package conv_pkg holds:
  - the DATA_WIDTH default
  - KERNEL_SIZE=3
  - NUM_TAPS=9
  - the tap-index constants shared with the adder tree
- One sub-module, conv_line_buffer: a depth-IMG_WIDTH shift FIFO with enable, instantiated twice (row r-1 and row r-2).

## Test plan
- 4x4 frame, in_data = 0..15, out_ready=1 → 4 windows. First window is win_0..8 = 0,1,2,4,5,6,8,9,10, one cycle after pixel 10. The others have bottom-right 11, 14, 15; frame_last only with 15.
- Same frame, out_ready low for 5 cycles on the first window → in_ready=0 and outputs frozen. After release, the window sequence is identical and nothing is lost or duplicated.
- Two 4x4 frames back-to-back (values 0..15, then 100..115) → 8 windows. The second frame's first window is 100,101,102,104,105,106,108,109,110.
- reset asserted after pixel 9 of a frame, then a fresh 4x4 frame → no window is emitted from the abandoned frame, and the outputs are exactly those of the first test.
- CONV_WINDOW_STRIDE2_EN, 5x5 frame, values 0..24 → exactly 4 windows, with bottom-right 12, 14, 22, 24; frame_last with 24. Without the macro → 9 windows.
- Random in_valid/out_ready gaps on a default 28x28 frame → 676 windows, each matching the reference-model neighbourhood.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: constants shared by the 3x3 window generator and the convolver adder tree
package conv_pkg;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int KERNEL_SIZE = 3;
    localparam int NUM_TAPS = KERNEL_SIZE * KERNEL_SIZE;
    // Tap k multiplies with kernel weight k; row-major, top-left first
    localparam int TAP_TOP_LEFT  = 0;
    localparam int TAP_TOP_MID   = 1;
    localparam int TAP_TOP_RIGHT = 2;
    localparam int TAP_MID_LEFT  = 3;
    localparam int TAP_CENTER    = 4;
    localparam int TAP_MID_RIGHT = 5;
    localparam int TAP_BOT_LEFT  = 6;
    localparam int TAP_BOT_MID   = 7;
    localparam int TAP_BOT_RIGHT = 8;
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel stream in, 3x3 window stream out
// slave = window generator side, master = producer/consumer side
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic in_valid, in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic out_valid, out_ready, frame_last;
    logic signed [DATA_WIDTH-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, frame_last,
        output win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, frame_last,
        input  win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8
    );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-entry shift FIFO; delayed is the pixel shifted in DEPTH enables ago
// Ports: clk, en (shift), pixel (new entry), delayed (oldest entry)
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH = 28
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] pixel,
    output logic [DATA_WIDTH-1:0] delayed
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (en) sr <= {sr[DEPTH-2:0], pixel};
    end
    assign delayed = sr[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator feeding the convolver multiplier bank
// Ports: clk; reset (sync, active-high); bus (slave): raster pixel stream in,
// window stream out on win_0..win_8 with frame_last on the final window of a frame.
// Build option CONV_WINDOW_STRIDE2_EN: emit only windows whose bottom-right has even row and col.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input logic clk,
    input logic reset,
    conv_window_gen_if.slave bus
);
`ifdef CONV_WINDOW_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
`else
    localparam bit STRIDE2 = 1'b0;
`endif
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] END_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] END_ROW = RW'(IMG_HEIGHT - 1);
    // Bottom-right position of the last window a frame emits
    localparam logic [CW-1:0] LAST_COL = CW'(STRIDE2 ? (IMG_WIDTH - 1) / 2 * 2 : IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(STRIDE2 ? (IMG_HEIGHT - 1) / 2 * 2 : IMG_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic accept, emit;
    logic [DATA_WIDTH-1:0] above1, above2;
    // Two columns left of the incoming pixel; element 0 is row r-2, element 2 is row r
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] col_old, col_mid;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps, win_q;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;
    assign emit = accept && row >= RW'(2) && col >= CW'(2) && (!STRIDE2 || (!row[0] && !col[0]));

    // Line buffers hold the previous two rows, so their outputs are the pixels directly above
    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) lb_row1 (
        .clk(clk), .en(accept), .pixel(bus.in_data), .delayed(above1)
    );
    conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) lb_row2 (
        .clk(clk), .en(accept), .pixel(above1), .delayed(above2)
    );

    // The incoming column completes the window, so it is taken straight from the inputs
    assign taps = {bus.in_data, col_mid[2], col_old[2],
                   above1,      col_mid[1], col_old[1],
                   above2,      col_mid[0], col_old[0]};

    always_ff @(posedge clk) begin
        if (accept) begin
            col_old <= col_mid;
            col_mid <= {bus.in_data, above1, above2};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
            bus.out_valid <= 1'b0;
            bus.frame_last <= 1'b0;
            win_q <= '0;
        end else begin
            if (accept) begin
                col <= (col == END_COL) ? '0 : col + 1'b1;
                if (col == END_COL) row <= (row == END_ROW) ? '0 : row + 1'b1;
            end
            if (emit) begin
                bus.out_valid <= 1'b1;
                bus.frame_last <= row == LAST_ROW && col == LAST_COL;
                win_q <= taps;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.frame_last <= 1'b0;
            end
        end
    end

    assign bus.win_0 = win_q[TAP_TOP_LEFT];
    assign bus.win_1 = win_q[TAP_TOP_MID];
    assign bus.win_2 = win_q[TAP_TOP_RIGHT];
    assign bus.win_3 = win_q[TAP_MID_LEFT];
    assign bus.win_4 = win_q[TAP_CENTER];
    assign bus.win_5 = win_q[TAP_MID_RIGHT];
    assign bus.win_6 = win_q[TAP_BOT_LEFT];
    assign bus.win_7 = win_q[TAP_BOT_MID];
    assign bus.win_8 = win_q[TAP_BOT_RIGHT];
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: 4x4, 5x5 and 28x28 instances checked against a frame-array reference model
module tb_conv_window_gen;
    typedef struct packed {
        logic [8:0][15:0] taps;
        logic last;
    } exp_t;
    localparam int WS [3] = '{4, 5, 28};
    localparam int HS [3] = '{4, 5, 28};
`ifdef CONV_WINDOW_STRIDE2_EN
    localparam bit STRIDE = 1'b1;
`else
    localparam bit STRIDE = 1'b0;
`endif
    localparam int ST = STRIDE ? 2 : 1;
    localparam int PR5 = STRIDE ? 2 : 3;
    localparam int N5 = PR5 * PR5;
    localparam int N28 = STRIDE ? 169 : 676;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iv [3];
    logic ordy [3];
    logic ir [3];
    logic ov [3];
    logic fl [3];
    logic [15:0] id [3];
    logic [8:0][15:0] win [3];
    int n_cmp = 0;
    int n_bad = 0;
    int nwin [3] = '{0, 0, 0};
    logic [8:0][15:0] wlog [64];
    logic flog [64];
    int nlog = 0;
    int lsel = 0;
    logic [8:0][15:0] held;
    bit done6 = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int W = WS[g];
        localparam int H = HS[g];
        localparam int TOTAL = STRIDE ? ((H - 3) / 2 + 1) * ((W - 3) / 2 + 1) : (H - 2) * (W - 2);
        conv_window_gen_if #(.DATA_WIDTH(16)) bus ();
        assign bus.in_valid = iv[g];
        assign bus.in_data = id[g];
        assign bus.out_ready = ordy[g];
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign fl[g] = bus.frame_last;
        assign win[g] = {bus.win_8, bus.win_7, bus.win_6, bus.win_5, bus.win_4,
                         bus.win_3, bus.win_2, bus.win_1, bus.win_0};
        conv_window_gen #(.DATA_WIDTH(16), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
            .clk(clk), .reset(reset), .bus(bus)
        );
        exp_t q [$];
        exp_t e;
        logic [15:0] img [W * H];
        int k = 0;
        int fcnt = 0;
        int r, c;
        always @(negedge clk) begin
            if (reset) begin
                q.delete();
                k = 0;
                fcnt = 0;
            end else begin
                check($sformatf("inst%0d out_valid", g), ov[g], q.size() != 0);
                if (ov[g] && ordy[g] && q.size() != 0) begin
                    e = q.pop_front();
                    check($sformatf("inst%0d window", g), {win[g], fl[g]}, {e.taps, e.last});
                    nwin[g]++;
                end
                if (iv[g] && ir[g]) begin
                    img[k] = id[g];
                    r = k / W;
                    c = k % W;
                    if (r >= 2 && c >= 2 && (!STRIDE || (r % 2 == 0 && c % 2 == 0))) begin
                        for (int a = 0; a < 3; a++)
                            for (int b = 0; b < 3; b++)
                                e.taps[a * 3 + b] = img[(r - 2 + a) * W + c - 2 + b];
                        e.last = fcnt == TOTAL - 1;
                        fcnt++;
                        q.push_back(e);
                    end
                    k = (k + 1) % (W * H);
                    if (k == 0) fcnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ov[lsel] && ordy[lsel] && nlog < 64) begin
            wlog[nlog] = win[lsel];
            flog[nlog] = fl[lsel];
            nlog++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int s, input logic [15:0] v);
        bit ok = 1'b0;
        iv[s] = 1'b1;
        id[s] = v;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (ir[s]) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        iv[s] = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send inst%0d: got no accept, want accept", s);
            tick(1);
        end
    endtask

    task automatic check_t1(input string p);
        check({p, " count"}, nlog, 4);
        check({p, " first window"}, wlog[0],
              {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0});
        check({p, " br1"}, wlog[1][8], 11);
        check({p, " br2"}, wlog[2][8], 14);
        check({p, " br3"}, wlog[3][8], 15);
        check({p, " frame_last"}, {flog[3], flog[2], flog[1], flog[0]}, 4'b1000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0;
            ordy[s] = 1'b1;
            id[s] = '0;
        end
        tick(2);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("reset out_valid", ov[s], 0);
            check("reset frame_last", fl[s], 0);
            check("reset win", win[s], '0);
            check("reset in_ready", ir[s], 1);
        end
        // basic 4x4 frame with latency probes
        lsel = 0;
        nlog = 0;
        for (int v = 0; v < 16; v++) begin
            send(0, 16'(v));
            if (v == 9) check("t1 no early window", ov[0], 0);
            if (v == 10) check("t1 latency", ov[0], 1);
        end
        tick(3);
        check_t1("t1");
        // backpressure on the first window
        nlog = 0;
        ordy[0] = 1'b0;
        fork
            for (int v = 0; v < 16; v++) send(0, 16'(v));
            begin
                for (int t = 0; t < 100 && !ov[0]; t++) @(negedge clk);
                check("t2 window seen", ov[0], 1);
                held = win[0];
                repeat (5) begin
                    @(negedge clk);
                    check("t2 stall in_ready", ir[0], 0);
                    check("t2 frozen", {ov[0], win[0]}, {1'b1, held});
                end
                @(posedge clk);
                #1;
                ordy[0] = 1'b1;
            end
        join
        tick(3);
        check_t1("t2");
        // two frames back to back
        nlog = 0;
        for (int v = 0; v < 16; v++) send(0, 16'(v));
        for (int v = 100; v < 116; v++) send(0, 16'(v));
        tick(3);
        check("t3 count", nlog, 8);
        check("t3 second frame first", wlog[4],
              {16'd110, 16'd109, 16'd108, 16'd106, 16'd105, 16'd104, 16'd102, 16'd101, 16'd100});
        check("t3 last br", wlog[7][8], 115);
        check("t3 frame_last", {flog[7], flog[4], flog[3], flog[0]}, 4'b1010);
        // mid-frame reset
        nlog = 0;
        for (int v = 0; v < 10; v++) send(0, 16'(v));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t4 reset out_valid", ov[0], 0);
        check("t4 reset win", win[0], '0);
        check("t4 reset in_ready", ir[0], 1);
        for (int v = 0; v < 16; v++) send(0, 16'(v));
        tick(3);
        check_t1("t4");
        // 5x5 frame: stride-dependent window set
        lsel = 1;
        nlog = 0;
        for (int v = 0; v < 25; v++) send(1, 16'(v));
        tick(3);
        check("t5 count", nlog, N5);
        check("t5 model count", nwin[1], N5);
        for (int j = 0; j < N5; j++) begin
            check($sformatf("t5 br%0d", j), wlog[j][8], 12 + (j / PR5) * 5 * ST + (j % PR5) * ST);
            check($sformatf("t5 last%0d", j), flog[j], j == N5 - 1);
        end
        // 28x28 frame with random gaps on both sides
        lsel = 2;
        fork
            begin
                for (int p = 0; p < 784; p++) begin
                    tick($urandom_range(0, 2));
                    send(2, 16'($urandom));
                end
                done6 = 1'b1;
            end
            begin
                while (!done6) begin
                    ordy[2] = $urandom_range(0, 3) != 0;
                    tick(1);
                end
                ordy[2] = 1'b1;
            end
        join
        tick(5);
        check("t6 window count", nwin[2], N28);
        check("t6 drained", ov[2], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
